// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive-side blocks:
//   UART_WIDTH   default byte width delivered by the UART receiver
//   regSel_e     CPU register select encoding (STATUS / DATA)
//   RX_VALID     status bit: at least one byte is waiting in the buffer
//   FULL         status bit: buffer cannot accept another byte
//   statusWord   packs the two status flags into a 32-bit CPU read word
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_WIDTH = 8;

  typedef enum logic {
    STATUS = 1'b0,
    DATA   = 1'b1
  } regSel_e;

  localparam int RX_VALID = 0;
  localparam int FULL     = 1;

  function automatic logic [31:0] statusWord(input logic isFull, input logic notEmpty);
    logic [31:0] word;
    word           = '0;
    word[FULL]     = isFull;
    word[RX_VALID] = notEmpty;
    return word;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with an asynchronously read head entry so the storage
// maps onto distributed RAM. Only the pointers and occupancy are reset; the
// storage array keeps whatever it held and is simply treated as empty.
//
// DEPTH must be a power of two (2..64) so the pointers wrap naturally.
//
// Ports:
//   clock     rising-edge clock
//   reset     synchronous active-high reset of pointers and occupancy
//   pushData  byte to store
//   pushEn    store pushData this edge (ignored while full)
//   popEn     discard the head entry this edge (ignored while empty)
//   headData  oldest stored entry (valid only when !empty)
//   full      occupancy == DEPTH
//   empty     occupancy == 0
//   level     occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pushEn,
  input  logic                     popEn,
  output logic [WIDTH-1:0]         headData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic [CNT_W-1:0]  count;
  logic              pushOk;
  logic              popOk;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

  // Guard against overflow/underflow here so callers may request freely.
  assign pushOk = pushEn && !full;
  assign popOk  = popEn && !empty;

  // Storage: no reset so the array infers as plain distributed RAM.
  always_ff @(posedge clock) begin
    if (pushOk) begin
      mem[wrPtr] <= pushData;
    end
  end

  assign headData = mem[rdPtr];

  // Pointers wrap modulo DEPTH by plain binary overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) begin
        wrPtr <= wrPtr + ADDR_W'(1);
      end
      if (popOk) begin
        rdPtr <= rdPtr + ADDR_W'(1);
      end
      case ({pushOk, popOk})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  countInRange: assert property (@(posedge clock) disable iff (reset)
    count <= CNT_W'(DEPTH));

  notFullAndEmpty: assert property (@(posedge clock) disable iff (reset)
    !(full && empty));

endmodule

// File: rtl/uart_rx_buffer.sv
// ---------------------------------------------------------------------------
// uart_rx_buffer
// Receive buffer between a UART receiver and a CPU load port. Bytes from the
// UART are queued in a sync_fifo; the CPU reads either a status word or the
// oldest byte through a registered one-cycle-latency read port that freezes
// while the CPU pipeline is stalled.
//
// Ports:
//   Clock        rising-edge clock
//   Reset        synchronous active-high reset
//   DataIn       byte from the UART receiver
//   DataInValid  DataIn holds a byte
//   DataInReady  buffer accepts a byte this cycle (registered occupancy only)
//   RdEn         CPU load to the buffer this cycle
//   RdSel        0 = status register, 1 = data register
//   stall        CPU stall; an RdEn during stall is ignored
//   RdData       registered read result, held until the next accepted read
//   Level        current occupancy
//
// Status word: bit 1 = full, bit 0 = byte available. Data read of an empty
// buffer returns zero. WIDTH must not exceed 32.
// ---------------------------------------------------------------------------
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = UART_WIDTH
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [WIDTH-1:0]        DataIn,
  input  logic                    DataInValid,
  output logic                    DataInReady,
  input  logic                    RdEn,
  input  logic                    RdSel,
  input  logic                    stall,
  output logic [31:0]             RdData,
  output logic [$clog2(DEPTH):0]  Level
);

  logic              fifoFull;
  logic              fifoEmpty;
  logic [WIDTH-1:0]  fifoHead;
  logic              pushReq;
  logic              popReq;
  logic              rdVld_p0;
  logic [31:0]       rdDataNext_p0;
  logic [31:0]       rdData_p1;

  // Ready depends only on the occupancy register and Reset, never on
  // DataInValid, so upstream sees no combinational loop through this block.
  assign DataInReady = !fifoFull && !Reset;
  assign pushReq     = DataInValid && DataInReady;

  // ---- p0: CPU request decode against pre-edge FIFO state ----
  assign rdVld_p0 = RdEn && !stall;

  // An empty data read must not pop, so a byte pushed in the same cycle
  // stays in the buffer and the read returns zero.
  assign popReq = rdVld_p0 && (RdSel == DATA) && !fifoEmpty;

  always_comb begin
    rdDataNext_p0 = '0;
    if (RdSel == DATA) begin
      if (!fifoEmpty) begin
        rdDataNext_p0[WIDTH-1:0] = fifoHead;
      end
    end else begin
      rdDataNext_p0 = statusWord(fifoFull, !fifoEmpty);
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) uFifo (
    .clock    (Clock),
    .reset    (Reset),
    .pushData (DataIn),
    .pushEn   (pushReq),
    .popEn    (popReq),
    .headData (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .level    (Level)
  );

  // ---- p1: registered read result, held between accepted reads ----
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rdData_p1 <= '0;
    end else if (rdVld_p0) begin
      rdData_p1 <= rdDataNext_p0;
    end
  end

  assign RdData = rdData_p1;

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic                    Clock;
  logic                    Reset;
  logic [WIDTH-1:0]        DataIn;
  logic                    DataInValid;
  logic                    DataInReady;
  logic                    RdEn;
  logic                    RdSel;
  logic                    stall;
  logic [31:0]             RdData;
  logic [$clog2(DEPTH):0]  Level;

  uart_rx_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .DataIn      (DataIn),
    .DataInValid (DataInValid),
    .DataInReady (DataInReady),
    .RdEn        (RdEn),
    .RdSel       (RdSel),
    .stall       (stall),
    .RdData      (RdData),
    .Level       (Level)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of bytes plus the last accepted read result.
  logic [7:0]  mq[$];
  logic [31:0] mRd = 32'h0;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  din;
    logic        re;
    logic        rs;
    logic        st;
    logic [31:0] expRd;
    int          expLvl;
    logic        expRdy;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check ready before the edge, advance the
  // model at the edge, check read data and level just after it.
  task automatic cyc(input logic r, input logic v, input logic [7:0] d,
                     input logic re, input logic rs, input logic st,
                     output logic rdyObs);
    int sz;
    bit popIt;
    Reset = r; DataInValid = v; DataIn = d; RdEn = re; RdSel = rs; stall = st;
    #1;
    rdyObs = DataInReady;
    chk("modelReady", 32'(DataInReady), 32'((mq.size() != DEPTH) && !r));
    @(posedge Clock);
    sz = mq.size();
    popIt = 1'b0;
    if (r) begin
      mq.delete();
      mRd = 32'h0;
    end else begin
      if (re && !st) begin
        if (rs) begin
          if (sz > 0) begin
            mRd = {24'h0, mq[0]};
            popIt = 1'b1;
          end else begin
            mRd = 32'h0;
          end
        end else begin
          mRd = {30'h0, (sz == DEPTH), (sz != 0)};
        end
      end
      if (popIt) void'(mq.pop_front());
      if (v && sz != DEPTH) mq.push_back(d);
    end
    #1;
    chk("modelRdData", RdData, mRd);
    chk("modelLevel", 32'(Level), 32'(mq.size()));
  endtask

  logic rdy;

  initial begin
    Reset = 1'b1; DataInValid = 1'b0; DataIn = '0; RdEn = 1'b0; RdSel = 1'b0; stall = 1'b0;

    //            rst  vld  din    re   rs   st   expRd       lvl rdy
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,      0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 32'h0,      0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0,      0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 8'h7A, 1'b0, 1'b0, 1'b0, 32'h0,      1, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 8'h0D, 1'b1, 1'b0, 1'b0, 32'h1,      2, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 32'h1,      3, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h7A,     2, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h7A,     2, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0D,     1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0A,     0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,      0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 32'h0,      1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 32'h55,     1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h1,      1, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h66,     0, 1'b1};

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].rst, tbl[i].vld, tbl[i].din, tbl[i].re, tbl[i].rs, tbl[i].st, rdy);
      chk($sformatf("tbl%0d_ready", i), 32'(rdy), 32'(tbl[i].expRdy));
      chk($sformatf("tbl%0d_rdData", i), RdData, tbl[i].expRd);
      chk($sformatf("tbl%0d_level", i), 32'(Level), 32'(tbl[i].expLvl));
    end

    // Fill to full with valid held high; ninth byte must wait upstream.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, rdy);
      chk("fillLevel", 32'(Level), 32'(i));
    end
    cyc(1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, rdy);
    chk("fullReady", 32'(rdy), 32'h0);
    chk("fullLevel", 32'(Level), 32'd8);
    cyc(1'b0, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0, rdy);
    chk("fullStatus", RdData, 32'h3);
    cyc(1'b0, 1'b1, 8'h09, 1'b1, 1'b1, 1'b0, rdy);
    chk("popFromFullReady", 32'(rdy), 32'h0);
    chk("popFromFullData", RdData, 32'h01);
    chk("popFromFullLevel", 32'(Level), 32'd7);
    cyc(1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, rdy);
    chk("readyAfterPop", 32'(rdy), 32'h1);
    chk("ninthAccepted", 32'(Level), 32'd8);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, rdy);
      chk("drainOrder", RdData, 32'(i + 2));
    end

    // Push and pop every cycle across several pointer wraps.
    cyc(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, rdy);
    for (int i = 0; i < 19; i++) begin
      cyc(1'b0, 1'b1, 8'(8'h11 + i), 1'b1, 1'b1, 1'b0, rdy);
      chk("streamData", RdData, 32'(8'h10 + i));
      chk("streamLevel", 32'(Level), 32'd1);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, rdy);
    chk("streamLast", RdData, 32'h23);

    // Data read held off by stall, then released.
    cyc(1'b0, 1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, rdy);
    cyc(1'b0, 1'b1, 8'hCD, 1'b0, 1'b0, 1'b0, rdy);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, rdy);
      chk("stallHoldData", RdData, 32'h23);
      chk("stallNoPop", 32'(Level), 32'd2);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, rdy);
    chk("stallRelease", RdData, 32'hAB);
    chk("stallReleaseLevel", 32'(Level), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, rdy);
    chk("holdAfterRead", RdData, 32'hAB);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, rdy);
    chk("secondAfterStall", RdData, 32'hCD);

    // Reset during a push at level 5.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0, rdy);
    chk("preResetLevel", 32'(Level), 32'd5);
    cyc(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, rdy);
    chk("midResetLevel", 32'(Level), 32'd0);
    chk("midResetRdData", RdData, 32'h0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, rdy);
    chk("postResetReady", 32'(rdy), 32'h1);
    chk("postResetStatus", RdData, 32'h0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, rdy);
    chk("pushDiscarded", RdData, 32'h0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 9) < 6),
          8'($urandom),
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 3) == 0),
          rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
